// File: rtl/sr_ff_bank.sv
// Bank of independent synchronous SR flip-flops with edge pulses
// and a saturating S=R=1 conflict counter.
module sr_ff_bank #(
    parameter int               WIDTH = 4,
    parameter int               MODE  = 0,
    parameter logic [WIDTH-1:0] INIT  = '0,
    parameter int               CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_rise,
    output logic [WIDTH-1:0] q_fall,
    output logic             conflict,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic             r_conf;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_q_nxt;
    logic             w_conf;

    always_comb begin
        w_q_nxt = r_q;
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                unique case ({s[i], r[i]})
                    2'b10:   w_q_nxt[i] = 1'b1;
                    2'b01:   w_q_nxt[i] = 1'b0;
                    2'b11: begin
                        // Out-of-range MODE degrades to HOLD
                        if (MODE == 1)      w_q_nxt[i] = 1'b1;
                        else if (MODE == 2) w_q_nxt[i] = 1'b0;
                        else if (MODE == 3) w_q_nxt[i] = ~r_q[i];
                        else                w_q_nxt[i] = r_q[i];
                    end
                    default: w_q_nxt[i] = r_q[i];
                endcase
            end
        end
    end

    assign w_conf = en & (|(s & r));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q    <= INIT;
            r_rise <= '0;
            r_fall <= '0;
            r_conf <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_q    <= w_q_nxt;
            r_rise <= ~r_q & w_q_nxt;
            r_fall <= r_q & ~w_q_nxt;
            r_conf <= w_conf;
            // Clear wins over a same-cycle increment
            if (clr_cnt) begin
                r_cnt <= '0;
            end else if (w_conf && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign q            = r_q;
    assign q_rise       = r_rise;
    assign q_fall       = r_fall;
    assign conflict     = r_conf;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench for sr_ff_bank: five instances (MODE 0..3, CNT_W=8,
// plus MODE 3 with CNT_W=2) driven in parallel against a reference model.
module tb_sr_ff_bank;

    localparam int         NI   = 5;
    localparam logic [3:0] INIT = 4'b1010;

    logic       clk = 1'b0;
    logic       reset, en, clr_cnt;
    logic [3:0] s, r;

    logic [3:0] d_q    [NI];
    logic [3:0] d_rise [NI];
    logic [3:0] d_fall [NI];
    logic       d_conf [NI];
    logic [7:0] d_cnt  [NI];

    int md [NI] = '{0, 1, 2, 3, 3};
    int mx [NI] = '{255, 255, 255, 255, 3};

    logic [3:0] m_q    [NI];
    logic [3:0] m_rise [NI];
    logic [3:0] m_fall [NI];
    logic       m_conf [NI];
    int         m_cnt  [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int CW = (k == 4) ? 2 : 8;
        logic [CW-1:0] w_cnt;
        sr_ff_bank #(
            .WIDTH (4),
            .MODE  ((k == 4) ? 3 : k),
            .INIT  (INIT),
            .CNT_W (CW)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .en           (en),
            .s            (s),
            .r            (r),
            .clr_cnt      (clr_cnt),
            .q            (d_q[k]),
            .q_rise       (d_rise[k]),
            .q_fall       (d_fall[k]),
            .conflict     (d_conf[k]),
            .conflict_cnt (w_cnt)
        );
        assign d_cnt[k] = 8'(w_cnt);
    end

    // Behavioural model, evaluated once per rising edge
    task automatic model_step();
        logic [3:0] nq;
        for (int k = 0; k < NI; k++) begin
            if (reset) begin
                m_q[k] = INIT; m_rise[k] = 0; m_fall[k] = 0;
                m_conf[k] = 0; m_cnt[k] = 0;
            end else begin
                nq = m_q[k];
                if (en) begin
                    for (int i = 0; i < 4; i++) begin
                        if (s[i] && !r[i]) nq[i] = 1'b1;
                        else if (r[i] && !s[i]) nq[i] = 1'b0;
                        else if (s[i] && r[i]) begin
                            if (md[k] == 1) nq[i] = 1'b1;
                            else if (md[k] == 2) nq[i] = 1'b0;
                            else if (md[k] == 3) nq[i] = ~m_q[k][i];
                        end
                    end
                end
                m_rise[k] = ~m_q[k] & nq;
                m_fall[k] = m_q[k] & ~nq;
                m_conf[k] = en && ((s & r) != 4'b0);
                if (clr_cnt) m_cnt[k] = 0;
                else if (m_conf[k] && m_cnt[k] < mx[k]) m_cnt[k]++;
                m_q[k] = nq;
            end
        end
    endtask

    task automatic cyc(input logic rs, input logic e, input logic [3:0] ss,
                       input logic [3:0] rr, input logic cc);
        reset = rs; en = e; s = ss; r = rr; clr_cnt = cc;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        cyc(1, 0, 4'h0, 4'h0, 0);
        for (int k = 0; k < NI; k++) begin
            total++;
            if (d_q[k] !== INIT || d_rise[k] !== 4'h0 || d_fall[k] !== 4'h0
                || d_conf[k] !== 1'b0 || d_cnt[k] !== 8'd0) begin
                bad++;
                $display("FAIL reset[%0d] q=%b rise=%b fall=%b conf=%b cnt=%0d want q=%b rest 0",
                         k, d_q[k], d_rise[k], d_fall[k], d_conf[k], d_cnt[k], INIT);
            end
        end
    endtask

    task automatic test_set_reset();
        cyc(0, 1, 4'h0, 4'hF, 0);
        cyc(0, 1, 4'b0101, 4'h0, 0);
        for (int k = 0; k < NI; k++) begin
            total++;
            if (d_q[k] !== 4'b0101 || d_rise[k] !== 4'b0101 || d_fall[k] !== 4'b0000) begin
                bad++;
                $display("FAIL set[%0d] q=%b rise=%b fall=%b want 0101/0101/0000",
                         k, d_q[k], d_rise[k], d_fall[k]);
            end
        end
        cyc(0, 1, 4'h0, 4'b0001, 0);
        for (int k = 0; k < NI; k++) begin
            total++;
            if (d_q[k] !== 4'b0100 || d_rise[k] !== 4'b0000 || d_fall[k] !== 4'b0001) begin
                bad++;
                $display("FAIL clear[%0d] q=%b rise=%b fall=%b want 0100/0000/0001",
                         k, d_q[k], d_rise[k], d_fall[k]);
            end
        end
    endtask

    task automatic test_disable();
        logic [3:0] saved [NI];
        for (int k = 0; k < NI; k++) saved[k] = d_q[k];
        for (int c = 0; c < 3; c++) begin
            cyc(0, 0, 4'hF, (c == 2) ? 4'hF : 4'h0, 0);
            for (int k = 0; k < NI; k++) begin
                total++;
                if (d_q[k] !== saved[k] || d_rise[k] !== 4'h0 || d_fall[k] !== 4'h0
                    || d_conf[k] !== 1'b0) begin
                    bad++;
                    $display("FAIL disable[%0d] q=%b rise=%b fall=%b conf=%b want q=%b rest 0",
                             k, d_q[k], d_rise[k], d_fall[k], d_conf[k], saved[k]);
                end
            end
        end
    endtask

    task automatic test_modes();
        logic exp0 [NI] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic tog  [3]  = '{1'b0, 1'b1, 1'b0};
        int   prev [NI];
        cyc(0, 1, 4'h0, 4'hF, 0);
        for (int k = 0; k < NI; k++) prev[k] = int'(d_cnt[k]);
        cyc(0, 1, 4'b0001, 4'b0001, 0);
        for (int k = 0; k < NI; k++) begin
            total++;
            if (d_q[k][0] !== exp0[k] || d_conf[k] !== 1'b1
                || int'(d_cnt[k]) != ((prev[k] < mx[k]) ? prev[k] + 1 : prev[k])) begin
                bad++;
                $display("FAIL mode[%0d] q0=%b conf=%b cnt=%0d want q0=%b conf=1 cnt=%0d",
                         k, d_q[k][0], d_conf[k], d_cnt[k], exp0[k], prev[k] + 1);
            end
        end
        for (int c = 0; c < 3; c++) begin
            cyc(0, 1, 4'b0001, 4'b0001, 0);
            total++;
            if (d_q[3][0] !== tog[c] || d_conf[3] !== 1'b1 || d_cnt[3] !== 8'(prev[3] + 2 + c)
                || d_rise[3][0] !== tog[c] || d_fall[3][0] !== ~tog[c]) begin
                bad++;
                $display("FAIL toggle[%0d] q0=%b rise0=%b fall0=%b cnt=%0d want q0=%b cnt=%0d",
                         c, d_q[3][0], d_rise[3][0], d_fall[3][0], d_cnt[3], tog[c], prev[3] + 2 + c);
            end
        end
    endtask

    task automatic test_saturate();
        logic [7:0] exp [5] = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};
        cyc(1, 0, 4'h0, 4'h0, 0);
        for (int c = 0; c < 5; c++) begin
            cyc(0, 1, 4'hF, 4'hF, 0);
            total++;
            if (d_cnt[4] !== exp[c] || d_cnt[0] !== 8'(c + 1)) begin
                bad++;
                $display("FAIL sat[%0d] cnt2=%0d cnt8=%0d want %0d/%0d",
                         c, d_cnt[4], d_cnt[0], exp[c], c + 1);
            end
        end
        cyc(0, 1, 4'hF, 4'hF, 1);
        for (int k = 0; k < NI; k++) begin
            total++;
            if (d_cnt[k] !== 8'd0 || d_conf[k] !== 1'b1) begin
                bad++;
                $display("FAIL clr_cnt[%0d] cnt=%0d conf=%b want 0/1", k, d_cnt[k], d_conf[k]);
            end
        end
    endtask

    task automatic test_reset_midrun();
        cyc(0, 1, 4'b0001, 4'b0001, 0);
        cyc(0, 1, 4'b0001, 4'b0001, 0);
        cyc(1, 1, 4'b0001, 4'b0001, 1);
        for (int k = 0; k < NI; k++) begin
            total++;
            if (d_q[k] !== INIT || d_rise[k] !== 4'h0 || d_fall[k] !== 4'h0
                || d_conf[k] !== 1'b0 || d_cnt[k] !== 8'd0) begin
                bad++;
                $display("FAIL rst_mid[%0d] q=%b rise=%b fall=%b conf=%b cnt=%0d",
                         k, d_q[k], d_rise[k], d_fall[k], d_conf[k], d_cnt[k]);
            end
        end
        cyc(0, 1, 4'b0001, 4'b0001, 0);
        total++;
        if (d_q[3] !== 4'b1011 || d_rise[3] !== 4'b0001 || d_cnt[3] !== 8'd1) begin
            bad++;
            $display("FAIL resume1 q=%b rise=%b cnt=%0d want 1011/0001/1",
                     d_q[3], d_rise[3], d_cnt[3]);
        end
        cyc(0, 1, 4'b0001, 4'b0001, 0);
        total++;
        if (d_q[3] !== 4'b1010 || d_fall[3] !== 4'b0001 || d_cnt[3] !== 8'd2) begin
            bad++;
            $display("FAIL resume2 q=%b fall=%b cnt=%0d want 1010/0001/2",
                     d_q[3], d_fall[3], d_cnt[3]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            cyc(($urandom_range(31) == 0), ($urandom_range(3) != 0),
                4'($urandom), 4'($urandom), ($urandom_range(15) == 0));
            for (int k = 0; k < NI; k++) begin
                total++;
                if (d_q[k] !== m_q[k] || d_rise[k] !== m_rise[k] || d_fall[k] !== m_fall[k]
                    || d_conf[k] !== m_conf[k] || d_cnt[k] !== 8'(m_cnt[k])) begin
                    bad++;
                    $display("FAIL rand[%0d] inst%0d q=%b/%b rise=%b/%b fall=%b/%b conf=%b/%b cnt=%0d/%0d",
                             c, k, d_q[k], m_q[k], d_rise[k], m_rise[k], d_fall[k], m_fall[k],
                             d_conf[k], m_conf[k], d_cnt[k], m_cnt[k]);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; s = '0; r = '0; clr_cnt = 1'b0;
        for (int k = 0; k < NI; k++) begin
            m_q[k] = INIT; m_rise[k] = 0; m_fall[k] = 0; m_conf[k] = 0; m_cnt[k] = 0;
        end
        @(negedge clk);
        test_reset();
        test_set_reset();
        test_disable();
        test_modes();
        test_saturate();
        test_reset_midrun();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
